// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// The operands are split into GROUP-bit slices, and one slice is resolved per stage.
// Each stage passes on the operand bits it has not yet consumed, so the upper
// operand slices arrive skewed by one cycle per stage. It also passes on the sum
// bits resolved so far, so the full result comes out of the last stage aligned.
// A final output register adds the flags and holds everything under backpressure.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             cin_msb,
    output logic             ovf,
    output logic             zero
);

    localparam int NSTG = WIDTH / GROUP;
    localparam int NGRP = GROUP / 4;

    if (GROUP < 4 || (GROUP % 4) != 0 || (WIDTH % GROUP) != 0) begin : g_bad_params
        $error("pipelined_cla_addsub: WIDTH must be a multiple of GROUP, GROUP a multiple of 4");
    end

    // One GROUP-bit lookahead slice. It returns {carry_out, sum}.
    // Group carries are flattened sum-of-products over the 4-bit group G/P terms.
    // The bit carries inside a group are likewise flattened from that group's carry-in.
    function automatic logic [GROUP:0] cla_slice(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             ci);
        logic [GROUP-1:0] g, p, c;
        logic [NGRP-1:0]  gg, gp;
        logic [NGRP:0]    gc;
        logic             term, prod;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NGRP; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        for (int j = 0; j <= NGRP; j++) begin
            term = 1'b0;
            for (int i = 0; i < j; i++) begin
                prod = gg[i];
                for (int m = i + 1; m < j; m++) prod = prod & gp[m];
                term = term | prod;
            end
            prod = ci;
            for (int m = 0; m < j; m++) prod = prod & gp[m];
            gc[j] = term | prod;
        end
        for (int j = 0; j < NGRP; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        return {gc[NGRP], p ^ c};
    endfunction

    // The whole pipe advances only when the output register is free or being drained.
    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en & rst_n;

    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
        localparam int RW = WIDTH - gi * GROUP;       // operand bits still to resolve
        localparam int LW = (gi + 1) * GROUP;         // sum bits resolved after this stage
        localparam int UW = WIDTH - (gi + 1) * GROUP; // operand bits passed onward

        logic [RW-1:0]    src_a, src_b;
        logic             src_c, src_v;
        logic [GROUP:0]   slice_res;
        logic [LW-1:0]    s_d, s_q;
        logic             c_d, c_q, v_d, v_q;

        if (gi == 0) begin : g_src
            // First stage takes the operands directly, with B inverted for subtraction.
            always_comb begin
                src_a = a;
                src_b = sub ? ~b : b;
                src_c = sub ? 1'b1 : cin;
                src_v = in_valid;
                s_d   = slice_res[GROUP-1:0];
            end
        end else begin : g_src
            // Later stages take the skewed operands and the carry from the previous stage.
            always_comb begin
                src_a = g_stg[gi-1].g_ops.a_q;
                src_b = g_stg[gi-1].g_ops.b_q;
                src_c = g_stg[gi-1].c_q;
                src_v = g_stg[gi-1].v_q;
                s_d   = {slice_res[GROUP-1:0], g_stg[gi-1].s_q};
            end
        end

        // Resolve this stage's slice.
        always_comb begin
            slice_res = cla_slice(src_a[GROUP-1:0], src_b[GROUP-1:0], src_c);
            c_d       = slice_res[GROUP];
            v_d       = src_v;
        end

        // Stage register: resolved sum bits, carry and valid bit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                s_q <= s_d;
                c_q <= c_d;
                v_q <= v_d;
            end
        end

        if (UW > 0) begin : g_ops
            logic [UW-1:0] a_d, a_q, b_d, b_q;
            // Unresolved operand bits, delayed one more cycle toward their stage.
            always_comb begin
                a_d = src_a[RW-1:GROUP];
                b_d = src_b[RW-1:GROUP];
            end
            // Skew register for the remaining operand bits.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (gi == NSTG - 1) begin : g_last
            logic cm_d, cm_q;
            // The carry into the MSB is recovered from the MSB sum bit and the operand bits.
            always_comb cm_d = slice_res[GROUP-1] ^ src_a[GROUP-1] ^ src_b[GROUP-1];
            // Register the carry into the MSB alongside the final slice.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  cm_q <= 1'b0;
                else if (en) cm_q <= cm_d;
            end
        end
    end

    logic [WIDTH-1:0] res_s_d, res_s_q;
    logic             out_valid_d, out_valid_q;
    logic             cout_d, cout_q, cin_msb_d, cin_msb_q, ovf_d, ovf_q, zero_d, zero_q;

    // Derive the flags from the fully resolved result.
    always_comb begin
        out_valid_d = g_stg[NSTG-1].v_q;
        res_s_d     = g_stg[NSTG-1].s_q;
        cout_d      = g_stg[NSTG-1].c_q;
        cin_msb_d   = g_stg[NSTG-1].g_last.cm_q;
        ovf_d       = cout_d ^ cin_msb_d;
        zero_d      = ~|res_s_d;
    end

    // Output register: holds the presented result while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_s_q     <= '0;
            cout_q      <= 1'b0;
            cin_msb_q   <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (en) begin
            out_valid_q <= out_valid_d;
            res_s_q     <= res_s_d;
            cout_q      <= cout_d;
            cin_msb_q   <= cin_msb_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s         = res_s_q;
    assign cout      = cout_q;
    assign cin_msb   = cin_msb_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub.
// Three configurations run in lockstep on shared handshakes: 32/8, 16/4 and 64/16.
// All three have a four-cycle latency. Expected results are pushed on acceptance
// and popped by an independent monitor whenever a result is transferred.
module tb_pipelined_cla_addsub;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, out_ready, cin, sub;
    logic [63:0] a64, b64;
    logic [2:0]  in_ready_w, out_valid_w, cout_w, cmsb_w, ovf_w, zero_w;
    logic [31:0] s0;
    logic [15:0] s1;
    logic [63:0] s2;
    logic [2:0][63:0] s_w;

    always_comb begin
        s_w[0] = {32'd0, s0};
        s_w[1] = {48'd0, s1};
        s_w[2] = s2;
    end

    pipelined_cla_addsub #(.WIDTH(32), .GROUP(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .a(a64[31:0]), .b(b64[31:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .s(s0),
        .cout(cout_w[0]), .cin_msb(cmsb_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0]));

    pipelined_cla_addsub #(.WIDTH(16), .GROUP(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .a(a64[15:0]), .b(b64[15:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .s(s1),
        .cout(cout_w[1]), .cin_msb(cmsb_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1]));

    pipelined_cla_addsub #(.WIDTH(64), .GROUP(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .a(a64), .b(b64), .cin(cin), .sub(sub),
        .out_valid(out_valid_w[2]), .out_ready(out_ready), .s(s2),
        .cout(cout_w[2]), .cin_msb(cmsb_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2]));

    typedef struct {
        logic [2:0][63:0] s;
        logic [2:0][3:0]  f;     // {cout, cin_msb, ovf, zero}
        int               acc;
        bit               chk_lat;
        int               id;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_sent = 0;
    bit   push_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s op=%0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Reference: plain wide addition masked to the configuration width.
    function automatic logic [67:0] model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                          input logic ci, input logic sb);
        logic [63:0] mask, aa, bb, sm;
        logic [64:0] full;
        logic        c0, co, cm;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        aa   = av & mask;
        bb   = (sb ? ~bv : bv) & mask;
        c0   = sb ? 1'b1 : ci;
        full = {1'b0, aa} + {1'b0, bb} + {64'd0, c0};
        sm   = full[63:0] & mask;
        co   = full[w];
        cm   = sm[w-1] ^ aa[w-1] ^ bb[w-1];
        return {co, cm, co ^ cm, (sm == 64'd0), sm};
    endfunction

    // Drive one operation and hold it until accepted. The 32-bit expectation is
    // either hand-computed (use_hand) or taken from the reference model.
    task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic ci, input logic sb,
                        input bit use_hand, input logic [31:0] hs, input logic [3:0] hf, input bit lat);
        exp_t        e;
        logic [67:0] m;
        logic        rdy;
        int          wait_n;
        int          widths [3];
        widths[0] = 32; widths[1] = 16; widths[2] = 64;
        a64 = av; b64 = bv; cin = ci; sub = sb; in_valid = 1'b1;
        for (int d = 0; d < 3; d++) begin
            m       = model(widths[d], av, bv, ci, sb);
            e.s[d]  = m[63:0];
            e.f[d]  = m[67:64];
        end
        if (use_hand) begin
            e.s[0] = {32'd0, hs};
            e.f[0] = hf;
        end
        e.chk_lat = lat;
        e.id      = n_sent;
        rdy       = 1'b0;
        wait_n    = 0;
        while (!rdy) begin
            @(negedge clk);
            rdy = in_ready_w[0];
            @(posedge clk);
            wait_n++;
            if (!rdy && wait_n > 200) begin
                $display("FAIL accept_timeout op=%0d: in_ready stuck at 0", n_sent);
                $fatal(1, "accept timeout");
            end
        end
        e.acc = cyc + 1;
        if (push_en) sb_q.push_back(e);
        n_sent++;
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_pending", -1, 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: compare every transferred result and check holding behaviour under stall.
    initial begin
        logic             stall_prev;
        logic [2:0][63:0] snap_s;
        logic [2:0][3:0]  snap_f;
        logic [3:0]       fl;
        exp_t             e;
        stall_prev = 1'b0;
        snap_s     = '0;
        snap_f     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (out_valid_w[1] !== out_valid_w[0] || out_valid_w[2] !== out_valid_w[0] ||
                    in_ready_w[1] !== in_ready_w[0] || in_ready_w[2] !== in_ready_w[0]) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL lockstep: out_valid=%b in_ready=%b not uniform", out_valid_w, in_ready_w);
                end
                if (stall_prev) begin
                    chk("hold_valid", -1, 64'(out_valid_w[0]), 64'd1);
                    for (int d = 0; d < 3; d++) begin
                        fl = {cout_w[d], cmsb_w[d], ovf_w[d], zero_w[d]};
                        chk($sformatf("hold_s[%0d]", d), -1, s_w[d], snap_s[d]);
                        chk($sformatf("hold_flags[%0d]", d), -1, 64'(fl), 64'(snap_f[d]));
                    end
                end
                if (out_valid_w[0] && !out_ready) begin
                    for (int d = 0; d < 3; d++)
                        chk($sformatf("in_ready_stall[%0d]", d), -1, 64'(in_ready_w[d]), 64'd0);
                end
                if (out_valid_w[0] && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_output: got s=%h expected no result", s_w[0]);
                    end else begin
                        e = sb_q.pop_front();
                        for (int d = 0; d < 3; d++) begin
                            fl = {cout_w[d], cmsb_w[d], ovf_w[d], zero_w[d]};
                            chk($sformatf("s[%0d]", d), e.id, s_w[d], e.s[d]);
                            chk($sformatf("flags[%0d]", d), e.id, 64'(fl), 64'(e.f[d]));
                        end
                        if (e.chk_lat)
                            chk("latency", e.id, 64'(cyc - e.acc), 64'd4);
                        $display("op %0d: s32=%h flags32=%b s16=%h s64=%h", e.id, s_w[0][31:0],
                                 {cout_w[0], cmsb_w[0], ovf_w[0], zero_w[0]}, s_w[1][15:0], s_w[2]);
                    end
                end
                stall_prev = out_valid_w[0] && !out_ready;
                for (int d = 0; d < 3; d++) begin
                    snap_s[d] = s_w[d];
                    snap_f[d] = {cout_w[d], cmsb_w[d], ovf_w[d], zero_w[d]};
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a64 = '0; b64 = '0; cin = 1'b0; sub = 1'b0;

        // Reset state
        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_out_valid[%0d]", d), -1, 64'(out_valid_w[d]), 64'd0);
            chk($sformatf("rst_s[%0d]", d), -1, s_w[d], 64'd0);
            chk($sformatf("rst_flags[%0d]", d), -1, 64'({cout_w[d], cmsb_w[d], ovf_w[d], zero_w[d]}), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("in_ready_after_rst[%0d]", d), -1, 64'(in_ready_w[d]), 64'd1);
        @(posedge clk);
        #1;

        // Single add in isolation: exact latency of four
        send(64'h0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, 32'h0001_0000, 4'b0000, 1'b1);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Directed boundary vectors, back to back
        send(64'hFFFF_FFFF, 64'h0,          1'b1, 1'b0, 1'b1, 32'h0000_0000, 4'b1101, 1'b1);
        send(64'h7FFF_FFFF, 64'h1,          1'b0, 1'b0, 1'b1, 32'h8000_0000, 4'b0110, 1'b1);
        send(64'h5,         64'h7,          1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 4'b0000, 1'b1);
        send(64'h8000_0000, 64'h1,          1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b1010, 1'b1);
        send(64'h1234_5678, 64'h1111_1111,  1'b0, 1'b0, 1'b1, 32'h2345_6789, 4'b0000, 1'b1);
        send(64'hDEAD_BEEF, 64'hDEAD_BEEF,  1'b0, 1'b1, 1'b1, 32'h0000_0000, 4'b1101, 1'b1);
        send(64'hA,         64'h3,          1'b1, 1'b1, 1'b1, 32'h0000_0007, 4'b1100, 1'b1);
        in_valid = 1'b0;
        drain();

        // 100 random operations at full throughput
        for (int i = 0; i < 100; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0, 32'd0, 4'd0, 1'b1);
        in_valid = 1'b0;
        drain();

        // Random stream with two three-cycle output stalls
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0, 32'd0, 4'd0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
                repeat (12) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight: none may emerge
        push_en = 1'b0;
        send(64'h1, 64'h2, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
        send(64'h3, 64'h4, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
        send(64'h5, 64'h6, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst_out_valid[%0d]", d), -1, 64'(out_valid_w[d]), 64'd0);
            chk($sformatf("midrst_s[%0d]", d), -1, s_w[d], 64'd0);
            chk($sformatf("midrst_flags[%0d]", d), -1, 64'({cout_w[d], cmsb_w[d], ovf_w[d], zero_w[d]}), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_en = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // The pipe still works after the mid-operation reset
        send(64'h0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, 32'h0001_0000, 4'b0000, 1'b1);
        in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
